// File: rtl/rr_prio_arb_if.sv
// Requester-side bundle for rr_prio_arb: level requests and done in, registered grant out.
// The master modport is the requester side, the slave modport is the arbiter side.
interface rr_prio_arb_if #(
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(WIDTH);

    logic [WIDTH-1:0] req;
    logic             done;
    logic [WIDTH-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_vld;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  gnt_vld,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output gnt_vld,
        output timeout
    );
endinterface

// File: rtl/rr_prio_arb.sv
// N-way arbiter with a registered one-hot grant held until done, abort or hold timeout.
// Fixed-priority (bit 0 highest) or round-robin selection, chosen at elaboration.
module rr_prio_arb #(
    parameter int WIDTH    = 8,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 0,
    parameter int IDW      = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_prio_arb_if.slave bus
);
    localparam int CW = (MAX_HOLD > 0 && $clog2(MAX_HOLD + 1) > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0]    HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [IDW-1:0]   LAST_ID   = IDW'(WIDTH - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [WIDTH-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_vld;
    logic             timeout;
    logic [CW-1:0]    cnt;
    logic [IDW-1:0]   ptr;

    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] pick;
    logic [WIDTH-1:0] win_oh;
    logic [IDW-1:0]   win_id;
    logic             rel_done;
    logic             rel_abort;
    logic             rel_to;

    // Round-robin searches from ptr upward first, then wraps to the lowest request.
    always_comb begin
        masked = bus.req & ({WIDTH{1'b1}} << ptr);
        if (RR_MODE != 0 && masked != '0)
            pick = masked;
        else
            pick = bus.req;
        win_oh = pick & ~(pick - ONE);
        win_id = '0;
        for (int i = 0; i < WIDTH; i++)
            if (win_oh[i]) win_id = IDW'(i);
    end

    assign rel_done  = bus.done;
    assign rel_abort = ~|(bus.req & gnt);
    assign rel_to    = (MAX_HOLD != 0) && (cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
            cnt     <= '0;
            ptr     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req != '0) begin
                        gnt     <= win_oh;
                        gnt_id  <= win_id;
                        gnt_vld <= 1'b1;
                        cnt     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (rel_done || rel_abort || rel_to) begin
                        gnt     <= '0;
                        gnt_id  <= '0;
                        gnt_vld <= 1'b0;
                        state   <= IDLE;
                        // done and abort take precedence, so a pulse means a pure timeout.
                        timeout <= !rel_done && !rel_abort;
                        if (RR_MODE != 0)
                            ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt;
    assign bus.gnt_id  = gnt_id;
    assign bus.gnt_vld = gnt_vld;
    assign bus.timeout = timeout;
endmodule

// File: tb/tb_rr_prio_arb.sv
// Bench for rr_prio_arb: three configurations (fixed, round-robin, round-robin with MAX_HOLD=4)
// checked every cycle against a behavioural model, plus directed literal expectations.
module tb_rr_prio_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_prio_arb_if #(.WIDTH(8)) if_fp ();
    rr_prio_arb_if #(.WIDTH(8)) if_rr ();
    rr_prio_arb_if #(.WIDTH(8)) if_to ();

    rr_prio_arb #(.WIDTH(8), .RR_MODE(0), .MAX_HOLD(0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(if_fp.slave));
    rr_prio_arb #(.WIDTH(8), .RR_MODE(1), .MAX_HOLD(0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr.slave));
    rr_prio_arb #(.WIDTH(8), .RR_MODE(1), .MAX_HOLD(4)) u_to (.clk(clk), .rst_n(rst_n), .bus(if_to.slave));

    int total = 0;
    int passed = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    function automatic logic [7:0] a_gnt(int k);
        case (k)
            0: return if_fp.gnt;
            1: return if_rr.gnt;
            default: return if_to.gnt;
        endcase
    endfunction
    function automatic logic [2:0] a_id(int k);
        case (k)
            0: return if_fp.gnt_id;
            1: return if_rr.gnt_id;
            default: return if_to.gnt_id;
        endcase
    endfunction
    function automatic logic a_vld(int k);
        case (k)
            0: return if_fp.gnt_vld;
            1: return if_rr.gnt_vld;
            default: return if_to.gnt_vld;
        endcase
    endfunction
    function automatic logic a_to(int k);
        case (k)
            0: return if_fp.timeout;
            1: return if_rr.timeout;
            default: return if_to.timeout;
        endcase
    endfunction

    // Behavioural model: one owner index per arbiter, a search start, and cycles held.
    int cfg_rr[3] = '{0, 1, 1};
    int cfg_mh[3] = '{0, 0, 4};
    int m_busy[3];
    int m_id[3];
    int m_ptr[3];
    int m_held[3];
    int m_to[3];

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0; m_id[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_to[k] = 0;
        end
    endtask

    task automatic m_step(int k, logic [7:0] r, logic d);
        int start;
        int found;
        m_to[k] = 0;
        if (m_busy[k] == 0) begin
            if (r != 8'h00) begin
                start = (cfg_rr[k] != 0) ? m_ptr[k] : 0;
                found = 0;
                for (int j = 0; j < 8; j++) begin
                    if (found == 0 && r[(start + j) % 8]) begin
                        m_id[k] = (start + j) % 8;
                        found = 1;
                    end
                end
                m_busy[k] = 1;
                m_held[k] = 0;
            end
        end else begin
            m_held[k]++;
            if (d || !r[m_id[k]] || (cfg_mh[k] != 0 && m_held[k] == cfg_mh[k])) begin
                if (!d && r[m_id[k]]) m_to[k] = 1;
                m_busy[k] = 0;
                m_ptr[k] = (m_id[k] + 1) % 8;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else begin
            m_step(0, if_fp.req, if_fp.done);
            m_step(1, if_rr.req, if_rr.done);
            m_step(2, if_to.req, if_to.done);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d gnt", k), 32'(a_gnt(k)), (m_busy[k] != 0) ? (32'd1 << m_id[k]) : 32'd0);
            chk($sformatf("dut%0d gnt_id", k), 32'(a_id(k)), (m_busy[k] != 0) ? 32'(m_id[k]) : 32'd0);
            chk($sformatf("dut%0d gnt_vld", k), 32'(a_vld(k)), 32'(m_busy[k] != 0));
            chk($sformatf("dut%0d timeout", k), 32'(a_to(k)), 32'(m_to[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(int k, string nm);
        int n = 0;
        while (!a_vld(k) && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " grant arrives"}, 32'(a_vld(k)), 32'd1);
    endtask

    task automatic pulse_done(int k);
        case (k)
            0: if_fp.done = 1'b1;
            1: if_rr.done = 1'b1;
            default: if_to.done = 1'b1;
        endcase
        tick();
        if_fp.done = 1'b0;
        if_rr.done = 1'b0;
        if_to.done = 1'b0;
    endtask

    logic [2:0] rr_seq [5] = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};

    initial begin
        if_fp.req = '0; if_fp.done = 1'b0;
        if_rr.req = '0; if_rr.done = 1'b0;
        if_to.req = '0; if_to.done = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle gnt", 32'(if_rr.gnt), 32'h0);
            chk("idle vld", 32'(if_fp.gnt_vld), 32'h0);
        end

        // Fixed priority: bit 2 always wins, bits 5 and 7 starve
        if_fp.req = 8'b1010_0100;
        for (int i = 0; i < 3; i++) begin
            wait_grant(0, "fp");
            chk("fp gnt", 32'(if_fp.gnt), 32'h04);
            pulse_done(0);
            chk("fp released", 32'(if_fp.gnt), 32'h0);
        end
        if_fp.req = '0;
        repeat (3) tick();

        // Round-robin rotation with wrap after id 7
        if_rr.req = 8'b1000_0101;
        for (int i = 0; i < 5; i++) begin
            wait_grant(1, "rr");
            chk("rr gnt_id", 32'(if_rr.gnt_id), 32'(rr_seq[i]));
            pulse_done(1);
            chk("rr idle gap", 32'(if_rr.gnt_vld), 32'h0);
        end
        if_rr.req = '0;
        repeat (2) tick();

        // Abort: ptr is 3 here, so id 3 wins; dropping req[3] releases it
        if_rr.req = 8'h28;
        wait_grant(1, "abort");
        chk("abort first id", 32'(if_rr.gnt_id), 32'd3);
        repeat (2) tick();
        if_rr.req = 8'h20;
        tick();
        chk("abort drop", 32'(if_rr.gnt), 32'h0);
        chk("abort no timeout", 32'(if_rr.timeout), 32'h0);
        tick();
        chk("abort regrant", 32'(if_rr.gnt), 32'h20);
        pulse_done(1);
        if_rr.req = '0;
        repeat (2) tick();

        // Hold timeout after exactly 4 granted cycles
        if_to.req = 8'h02;
        wait_grant(2, "to");
        chk("to gnt c1", 32'(if_to.gnt), 32'h02);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("to gnt c%0d", i), 32'(if_to.gnt), 32'h02);
        end
        tick();
        chk("to release gnt", 32'(if_to.gnt), 32'h0);
        chk("to pulse", 32'(if_to.timeout), 32'h1);
        tick();
        chk("to regrant id", 32'(if_to.gnt_id), 32'd1);
        chk("to pulse gone", 32'(if_to.timeout), 32'h0);
        if_to.req = '0;
        repeat (3) tick();

        // Asynchronous reset mid-grant; ptr (now 6) must return to 0
        if_rr.req = 8'h81;
        wait_grant(1, "areset");
        chk("areset pre id", 32'(if_rr.gnt_id), 32'd7);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset gnt", 32'(if_rr.gnt), 32'h0);
        chk("areset vld", 32'(if_rr.gnt_vld), 32'h0);
        tick();
        rst_n = 1'b1;
        wait_grant(1, "post reset");
        chk("post reset id", 32'(if_rr.gnt_id), 32'd0);
        pulse_done(1);
        if_rr.req = '0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end
endmodule

// File: doc/rr_prio_arb.md
Name: rr_prio_arb

Overview:
- Parametrised successor to the combinational fixed-priority arbiter.
- N requesters; registered one-hot grant, held until the owner signals done.
- Selectable fixed-priority or round-robin mode; optional hold-timeout watchdog.
- Sits in front of shared single-owner resources (bus master port, shared SRAM).

Parameters:
WIDTH, 8, number of requesters (>=2)
RR_MODE, 1, 1 = round-robin (rotating priority); 0 = fixed priority, bit 0 highest
MAX_HOLD, 0, max cycles a grant may be held; 0 disables the timeout
IDW, $clog2(WIDTH), width of gnt_id (derived, do not override)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  WIDTH  level request per requester; held until granted and served
done  input  1  owner finished; sampled only while gnt_vld=1
gnt  output  WIDTH  registered one-hot grant; all-zero when idle
gnt_id  output  IDW  binary index of granted requester; 0 when idle
gnt_vld  output  1  |gnt, registered
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - gnt=0, gnt_id=0, gnt_vld=0, timeout=0.
  - state=IDLE, hold counter=0, rr pointer=0.
- States: IDLE, BUSY.
- IDLE:
  - If req==0, stay in IDLE; outputs remain 0.
  - If req!=0, the winner is computed combinationally. gnt, gnt_id and gnt_vld are registered and appear at the next edge; go to BUSY.
  - Latency is 1 cycle from req sampled to grant visible.
- Winner selection:
  - RR_MODE=0: the lowest-index set bit of req, computed as req & ~(req-1).
  - RR_MODE=1: masked = req & {bits with index >= ptr}. If masked!=0, the winner is the lowest set bit of masked; otherwise it is the lowest set bit of req (wrap-around).
- BUSY:
  - Grant is held stable; changes in other req bits are ignored.
  - Release on the first of the following:
    - (a) done=1.
    - (b) the owner's req bit drops (abort).
    - (c) MAX_HOLD!=0 and the hold counter reaches MAX_HOLD-1, with neither (a) nor (b) true.
  - On release, at the next edge: gnt=0, gnt_vld=0, return to IDLE. Minimum turnaround is 1 idle cycle between grants.
  - The hold counter increments each BUSY cycle, clears on entry to BUSY, and saturates. Its width is $clog2(MAX_HOLD+1), minimum 1.
  - A timeout release pulses timeout=1 for exactly the cycle in which gnt first reads 0.
  - Simultaneous done and timeout condition: done wins, no timeout pulse.
- RR pointer:
  - On every release (any cause), ptr = (gnt_id+1) mod WIDTH. If gnt_id==WIDTH-1, ptr wraps to 0.
  - The pointer is unused and left static when RR_MODE=0.
- done while IDLE is ignored.
- An asynchronous reset mid-grant immediately drops gnt and clears the pointer and counter.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id always equals the encoded gnt.
  - A grant is never issued to a requester whose req was 0 in the sampling cycle.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> gnt=0, gnt_vld=0, timeout=0 throughout.
- Fixed priority (RR_MODE=0): req=8'b1010_0100 held; done pulsed 1 cycle after each grant -> grant sequence 8'h04, 8'h04, 8'h04; starvation of bits 5 and 7 is expected behaviour.
- Round-robin (RR_MODE=1): req=8'b1000_0101 held; done 1 cycle after each grant -> gnt_id sequence 0, 2, 7, 0, 2; one idle cycle between grants; ptr wraps after 7.
- Abort: grant to id 3, then deassert req[3] 2 cycles later with req[5]=1 -> gnt drops the next cycle; after the idle cycle gnt=8'h20; no timeout pulse.
- Timeout (MAX_HOLD=4): req=8'h02, done never asserted -> gnt=8'h02 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle; regrant to id 1 after the idle cycle.
- Async reset: drop rst_n mid-BUSY between edges -> gnt/gnt_vld go to 0 without a clock; after release with req=8'h81, the first grant is id 0 (ptr reset).
